// File: rtl/iq_classify_multi.sv
// iq_classify_multi: pipelined multi-channel linear discriminator for
// dispersive qubit readout. Each accepted I/Q sample is projected onto its
// channel's perpendicular vector, measured from a point on the decision line,
// and classified as ground (00), excited (01) or ambiguous (10). Per-channel
// saturating shot/excited counters support population readout.
// Latency is 3 cycles from valid_in to valid_out, full throughput.
// Optional build macro IQ_CLASSIFY_DIST_OUT_EN adds the dist_out projection
// output and a per-channel ambiguous counter read back on rd_ambig.
module iq_classify_multi #(
  parameter int DATA_W = 32,
  parameter int NUM_CH = 4,
  parameter int CH_W   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                     clk100,
  input  logic                     rst_n,
  input  logic                     valid_in,
  input  logic [CH_W-1:0]          ch_in,
  input  logic signed [DATA_W-1:0] i_val,
  input  logic signed [DATA_W-1:0] q_val,
  input  logic                     cfg_we,
  input  logic [CH_W-1:0]          cfg_ch,
  input  logic signed [DATA_W-1:0] cfg_i_pt,
  input  logic signed [DATA_W-1:0] cfg_q_pt,
  input  logic signed [DATA_W-1:0] cfg_i_perp,
  input  logic signed [DATA_W-1:0] cfg_q_perp,
  input  logic [DATA_W-1:0]        cfg_margin,
  input  logic                     clear,
  input  logic [CH_W-1:0]          rd_ch,
  output logic                     valid_out,
  output logic [CH_W-1:0]          ch_out,
  output logic [1:0]               state,
  output logic [CNT_W-1:0]         rd_shots,
  output logic [CNT_W-1:0]         rd_excited
`ifdef IQ_CLASSIFY_DIST_OUT_EN
  ,
  output logic signed [2*DATA_W+1:0] dist_out,
  output logic [CNT_W-1:0]           rd_ambig
`endif
);

  localparam int PW = 2*DATA_W + 1;
  localparam int DW = 2*DATA_W + 2;
  localparam logic [1:0] ST_GND = 2'b00;
  localparam logic [1:0] ST_EXC = 2'b01;
  localparam logic [1:0] ST_AMB = 2'b10;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Per-channel configuration
  logic signed [DATA_W-1:0] i_pt_q   [NUM_CH];
  logic signed [DATA_W-1:0] q_pt_q   [NUM_CH];
  logic signed [DATA_W-1:0] i_perp_q [NUM_CH];
  logic signed [DATA_W-1:0] q_perp_q [NUM_CH];
  logic [DATA_W-1:0]        margin_q [NUM_CH];

  // Configuration writes; out-of-range channels match no entry and are dropped
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        i_pt_q[k]   <= '0;
        q_pt_q[k]   <= '0;
        i_perp_q[k] <= '0;
        q_perp_q[k] <= '0;
        margin_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_we && (cfg_ch == CH_W'(k))) begin
          i_pt_q[k]   <= cfg_i_pt;
          q_pt_q[k]   <= cfg_q_pt;
          i_perp_q[k] <= cfg_i_perp;
          q_perp_q[k] <= cfg_q_perp;
          margin_q[k] <= cfg_margin;
        end
      end
    end
  end

  // Stage 1: offset from the line point. Config is read from the registers
  // before any same-cycle write lands, so a coincident sample sees the old set.
  logic                 in_ok;
  logic [CH_W-1:0]      ch_sel;
  logic signed [DATA_W:0] di_d, dq_d;

  assign in_ok  = valid_in && (int'(ch_in) < NUM_CH);
  assign ch_sel = in_ok ? ch_in : '0;
  assign di_d   = {i_val[DATA_W-1], i_val} - {i_pt_q[ch_sel][DATA_W-1], i_pt_q[ch_sel]};
  assign dq_d   = {q_val[DATA_W-1], q_val} - {q_pt_q[ch_sel][DATA_W-1], q_pt_q[ch_sel]};

  logic                     s1_vld_q;
  logic [CH_W-1:0]          s1_ch_q;
  logic signed [DATA_W:0]   s1_di_q, s1_dq_q;
  logic signed [DATA_W-1:0] s1_iperp_q, s1_qperp_q;
  logic [DATA_W-1:0]        s1_margin_q;

  // Stage 1 register
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q    <= 1'b0;
      s1_ch_q     <= '0;
      s1_di_q     <= '0;
      s1_dq_q     <= '0;
      s1_iperp_q  <= '0;
      s1_qperp_q  <= '0;
      s1_margin_q <= '0;
    end else begin
      s1_vld_q    <= in_ok;
      s1_ch_q     <= ch_sel;
      s1_di_q     <= di_d;
      s1_dq_q     <= dq_d;
      s1_iperp_q  <= i_perp_q[ch_sel];
      s1_qperp_q  <= q_perp_q[ch_sel];
      s1_margin_q <= margin_q[ch_sel];
    end
  end

  // Stage 2: component products
  logic signed [PW-1:0] pi_d, pq_d;
  assign pi_d = PW'(s1_di_q) * PW'(s1_iperp_q);
  assign pq_d = PW'(s1_dq_q) * PW'(s1_qperp_q);

  logic                 s2_vld_q;
  logic [CH_W-1:0]      s2_ch_q;
  logic signed [PW-1:0] s2_pi_q, s2_pq_q;
  logic [DATA_W-1:0]    s2_margin_q;

  // Stage 2 register
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      s2_vld_q    <= 1'b0;
      s2_ch_q     <= '0;
      s2_pi_q     <= '0;
      s2_pq_q     <= '0;
      s2_margin_q <= '0;
    end else begin
      s2_vld_q    <= s1_vld_q;
      s2_ch_q     <= s1_ch_q;
      s2_pi_q     <= pi_d;
      s2_pq_q     <= pq_d;
      s2_margin_q <= s1_margin_q;
    end
  end

  // Stage 3: projection sum and three-way decision against +/- margin
  logic signed [DW-1:0] d_s3, margin_ext;
  logic [1:0]           cls_d;

  assign d_s3       = DW'(s2_pi_q) + DW'(s2_pq_q);
  assign margin_ext = $signed(DW'(s2_margin_q));

  // Classify the stage-3 projection
  always_comb begin
    cls_d = ST_AMB;
    if (d_s3 > margin_ext)       cls_d = ST_EXC;
    else if (d_s3 < -margin_ext) cls_d = ST_GND;
  end

  logic            valid_q;
  logic [CH_W-1:0] ch_q;
  logic [1:0]      state_q;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
  logic signed [DW-1:0] dist_q;
`endif

  // Result register; channel/state/distance hold between results
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ch_q    <= '0;
      state_q <= ST_GND;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
      dist_q  <= '0;
`endif
    end else begin
      valid_q <= s2_vld_q;
      if (s2_vld_q) begin
        ch_q    <= s2_ch_q;
        state_q <= cls_d;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
        dist_q  <= d_s3;
`endif
      end
    end
  end

  // Population counters
  logic [CNT_W-1:0] shots_q [NUM_CH];
  logic [CNT_W-1:0] exc_q   [NUM_CH];
`ifdef IQ_CLASSIFY_DIST_OUT_EN
  logic [CNT_W-1:0] amb_q   [NUM_CH];
`endif

  // Count each result on its channel, saturating; clear overrides a same-cycle result
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shots_q[k] <= '0;
        exc_q[k]   <= '0;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
        amb_q[k]   <= '0;
`endif
      end
    end else if (clear) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shots_q[k] <= '0;
        exc_q[k]   <= '0;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
        amb_q[k]   <= '0;
`endif
      end
    end else if (valid_q) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (ch_q == CH_W'(k)) begin
          if (shots_q[k] != CNT_MAX) shots_q[k] <= shots_q[k] + 1'b1;
          if ((state_q == ST_EXC) && (exc_q[k] != CNT_MAX)) exc_q[k] <= exc_q[k] + 1'b1;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
          if ((state_q == ST_AMB) && (amb_q[k] != CNT_MAX)) amb_q[k] <= amb_q[k] + 1'b1;
`endif
        end
      end
    end
  end

  logic            rd_ok;
  logic [CH_W-1:0] rd_sel;
  logic [CNT_W-1:0] rd_shots_q, rd_exc_q;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
  logic [CNT_W-1:0] rd_amb_q;
`endif

  assign rd_ok  = int'(rd_ch) < NUM_CH;
  assign rd_sel = rd_ok ? rd_ch : '0;

  // Registered readback; unmapped channels read as zero
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      rd_shots_q <= '0;
      rd_exc_q   <= '0;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
      rd_amb_q   <= '0;
`endif
    end else begin
      rd_shots_q <= rd_ok ? shots_q[rd_sel] : '0;
      rd_exc_q   <= rd_ok ? exc_q[rd_sel]   : '0;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
      rd_amb_q   <= rd_ok ? amb_q[rd_sel]   : '0;
`endif
    end
  end

  assign valid_out  = valid_q;
  assign ch_out     = ch_q;
  assign state      = state_q;
  assign rd_shots   = rd_shots_q;
  assign rd_excited = rd_exc_q;
`ifdef IQ_CLASSIFY_DIST_OUT_EN
  assign dist_out   = dist_q;
  assign rd_ambig   = rd_amb_q;
`endif

endmodule

// File: tb/tb_iq_classify_multi.sv
// Bench for iq_classify_multi: a behavioural model (timestamped result queue,
// arithmetic projection, integer counters) checked every cycle, plus directed
// scenarios with literal expectations.
module tb_iq_classify_multi;
  localparam int DATA_W  = 32;
  localparam int NUM_CH  = 3;
  localparam int CH_W    = 2;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic clk100 = 1'b0;
  logic rst_n  = 1'b0;
  logic valid_in = 1'b0;
  logic [CH_W-1:0] ch_in = '0;
  logic signed [DATA_W-1:0] i_val = '0, q_val = '0;
  logic cfg_we = 1'b0;
  logic [CH_W-1:0] cfg_ch = '0;
  logic signed [DATA_W-1:0] cfg_i_pt = '0, cfg_q_pt = '0, cfg_i_perp = '0, cfg_q_perp = '0;
  logic [DATA_W-1:0] cfg_margin = '0;
  logic clear = 1'b0;
  logic [CH_W-1:0] rd_ch = '0;
  logic valid_out;
  logic [CH_W-1:0] ch_out;
  logic [1:0] state;
  logic [CNT_W-1:0] rd_shots, rd_excited;

  iq_classify_multi #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W)) dut (
    .clk100(clk100), .rst_n(rst_n), .valid_in(valid_in), .ch_in(ch_in),
    .i_val(i_val), .q_val(q_val), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
    .cfg_i_pt(cfg_i_pt), .cfg_q_pt(cfg_q_pt), .cfg_i_perp(cfg_i_perp),
    .cfg_q_perp(cfg_q_perp), .cfg_margin(cfg_margin), .clear(clear), .rd_ch(rd_ch),
    .valid_out(valid_out), .ch_out(ch_out), .state(state),
    .rd_shots(rd_shots), .rd_excited(rd_excited)
  );

  always #5 clk100 = ~clk100;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { int due; logic [1:0] ch; logic [1:0] st; } exp_t;
  typedef struct { logic [1:0] ch; logic [1:0] st; } res_t;
  exp_t pend[$];
  res_t obs[$];

  logic signed [DATA_W-1:0] m_ipt[NUM_CH], m_qpt[NUM_CH], m_iperp[NUM_CH], m_qperp[NUM_CH];
  logic [DATA_W-1:0] m_mg[NUM_CH];
  int m_shots[NUM_CH], m_exc[NUM_CH];
  int cyc = 0;
  logic cur_v = 1'b0;
  logic [1:0] cur_ch = '0, cur_st = '0;
  int exp_rs = 0, exp_re = 0;
  logic signed [67:0] di, dq, dd, mg;
  exp_t e;

  function automatic logic [1:0] classify(input logic signed [67:0] d, input logic signed [67:0] m);
    if (d > m) return 2'b01;
    if (d < -m) return 2'b00;
    return 2'b10;
  endfunction

  initial begin
    for (int k = 0; k < NUM_CH; k++) begin
      m_ipt[k] = '0; m_qpt[k] = '0; m_iperp[k] = '0; m_qperp[k] = '0; m_mg[k] = '0;
      m_shots[k] = 0; m_exc[k] = 0;
    end
    forever begin
      @(posedge clk100 or negedge rst_n);
      if (!rst_n) begin
        pend.delete();
        cur_v = 1'b0; cur_ch = '0; cur_st = '0; exp_rs = 0; exp_re = 0;
        for (int k = 0; k < NUM_CH; k++) begin
          m_ipt[k] = '0; m_qpt[k] = '0; m_iperp[k] = '0; m_qperp[k] = '0; m_mg[k] = '0;
          m_shots[k] = 0; m_exc[k] = 0;
        end
      end else begin
        if (int'(rd_ch) < NUM_CH) begin
          exp_rs = m_shots[rd_ch]; exp_re = m_exc[rd_ch];
        end else begin
          exp_rs = 0; exp_re = 0;
        end
        if (clear) begin
          for (int k = 0; k < NUM_CH; k++) begin m_shots[k] = 0; m_exc[k] = 0; end
        end else if (cur_v) begin
          if (m_shots[cur_ch] < CNT_MAX) m_shots[cur_ch]++;
          if (cur_st == 2'b01 && m_exc[cur_ch] < CNT_MAX) m_exc[cur_ch]++;
        end
        if (valid_in && int'(ch_in) < NUM_CH) begin
          di = i_val - m_ipt[ch_in];
          dq = q_val - m_qpt[ch_in];
          dd = di * m_iperp[ch_in] + dq * m_qperp[ch_in];
          mg = {36'd0, m_mg[ch_in]};
          pend.push_back('{cyc + 3, ch_in, classify(dd, mg)});
        end
        if (cfg_we && int'(cfg_ch) < NUM_CH) begin
          m_ipt[cfg_ch] = cfg_i_pt; m_qpt[cfg_ch] = cfg_q_pt;
          m_iperp[cfg_ch] = cfg_i_perp; m_qperp[cfg_ch] = cfg_q_perp;
          m_mg[cfg_ch] = cfg_margin;
        end
        cyc++;
        cur_v = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
          e = pend.pop_front();
          cur_v = 1'b1; cur_ch = e.ch; cur_st = e.st;
        end
      end
    end
  end

  // Per-cycle comparison against the model, and result capture for directed checks
  initial begin
    forever begin
      @(negedge clk100);
      chk("valid_out", valid_out, cur_v);
      chk("ch_out", ch_out, cur_ch);
      chk("state", state, cur_st);
      chk("rd_shots", rd_shots, exp_rs);
      chk("rd_excited", rd_excited, exp_re);
      if (valid_out) obs.push_back('{ch_out, state});
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk100);
    #1;
  endtask

  task automatic cfg(input int ch, input int ipt, input int qpt, input int ip, input int qp, input int m);
    cfg_we = 1'b1; cfg_ch = CH_W'(ch);
    cfg_i_pt = ipt; cfg_q_pt = qpt; cfg_i_perp = ip; cfg_q_perp = qp; cfg_margin = m;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic sample(input int ch, input int i, input int q);
    valid_in = 1'b1; ch_in = CH_W'(ch); i_val = i; q_val = q;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic chk_obs(input string nm, input int idx, input int ch, input int st);
    if (idx >= obs.size()) begin
      n_cmp++; n_fail++;
      $display("FAIL %s: result %0d missing, expected ch %0d state %0d", nm, idx, ch, st);
    end else begin
      chk({nm, "_ch"}, obs[idx].ch, ch);
      chk({nm, "_st"}, obs[idx].st, st);
    end
  endtask

  initial begin
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Margin 0: above, on, below the line
    cfg(0, 0, 5, 0, 1, 0);
    obs.delete();
    sample(0, 3, 7); sample(0, 3, 5); sample(0, 1, 1);
    repeat (5) tick();
    chk("t1_n", obs.size(), 3);
    chk_obs("t1_0", 0, 0, 1); chk_obs("t1_1", 1, 0, 2); chk_obs("t1_2", 2, 0, 0);

    // Margin 3: both band edges are ambiguous, negative inputs
    cfg(0, 0, 5, 0, 1, 3);
    obs.delete();
    sample(0, 0, 9); sample(0, 0, 7); sample(0, 0, 2); sample(0, 0, 1); sample(0, -10, -10);
    repeat (5) tick();
    chk("t2_n", obs.size(), 5);
    chk_obs("t2_0", 0, 0, 1); chk_obs("t2_1", 1, 0, 2); chk_obs("t2_2", 2, 0, 2);
    chk_obs("t2_3", 3, 0, 0); chk_obs("t2_4", 4, 0, 0);

    // Two channels with opposite perpendiculars
    cfg(0, 0, 5, 0, 1, 0);
    cfg(1, 0, 5, 0, -1, 0);
    obs.delete();
    sample(0, 2, 8); sample(1, 2, 8);
    repeat (5) tick();
    chk_obs("t3_0", 0, 0, 1); chk_obs("t3_1", 1, 1, 0);
    rd_ch = 1;
    tick();
    chk("t3_rd_shots", rd_shots, 1);
    chk("t3_rd_exc", rd_excited, 0);

    // Config write coincident with a sample on the same channel
    obs.delete();
    cfg_we = 1'b1; cfg_ch = 0; cfg_i_pt = 0; cfg_q_pt = 5; cfg_i_perp = 0; cfg_q_perp = -1; cfg_margin = 0;
    valid_in = 1'b1; ch_in = 0; i_val = 0; q_val = 7;
    tick();
    cfg_we = 1'b0; valid_in = 1'b0;
    sample(0, 0, 7);
    repeat (5) tick();
    chk("t4_n", obs.size(), 2);
    chk_obs("t4_0", 0, 0, 1); chk_obs("t4_1", 1, 0, 0);

    // Saturation, then clear coincident with a result
    cfg(2, 0, 0, 1, 0, 0);
    obs.delete();
    repeat (20) sample(2, 5, 0);
    repeat (5) tick();
    chk("t5_n", obs.size(), 20);
    rd_ch = 2;
    tick();
    chk("t5_sat_shots", rd_shots, 15);
    chk("t5_sat_exc", rd_excited, 15);
    obs.delete();
    sample(2, 5, 0);
    tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("t5_clr_res", obs.size(), 1);
    tick();
    chk("t5_clr_shots", rd_shots, 0);
    chk("t5_clr_exc", rd_excited, 0);

    // Reset with samples in flight, then a dropped out-of-range channel
    obs.delete();
    valid_in = 1'b1; ch_in = 0; i_val = 1; q_val = 1; tick();
    i_val = 2; q_val = 2; tick();
    i_val = 3; q_val = 3; tick();
    valid_in = 1'b0;
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    repeat (6) tick();
    chk("t6_no_out", obs.size(), 0);
    rd_ch = 0;
    tick();
    chk("t6_rst_shots", rd_shots, 0);
    sample(3, 1, 1);
    sample(0, 1, 1);
    repeat (5) tick();
    chk("t6_n", obs.size(), 1);
    chk_obs("t6_0", 0, 0, 2);
    tick();
    chk("t6_rd0_shots", rd_shots, 1);
    rd_ch = 3;
    tick();
    chk("t6_rd3_shots", rd_shots, 0);
    chk("t6_rd3_exc", rd_excited, 0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
